ysyx_ifu: RTL and testbench

Decoupled instruction fetch unit for the NPC core, replacing the single-cycle `pmem_read` fetch path with a ready/valid interface. It issues in-order word requests to instruction memory with up to `DEPTH` requests in flight. Returned instructions are buffered in a small FIFO and handed to the IDU with their PC. Redirects from the EXU flush the FIFO and drop any stale responses still in flight, so memory latency no longer has to be a single cycle.

---
 rtl/ysyx_pkg.sv | 15 +
 rtl/ysyx_ifu_fifo.sv | 74 +++++++
 rtl/ysyx_ifu.sv | 115 +++++++++++
 tb/tb_ysyx_ifu.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_pkg.sv
// rtl/ysyx_pkg.sv - shared widths, reset vector and IFU queue entry type
// Purpose: constants shared by the NPC front end.
// Contents: XLEN, RESET_PC, INST_W, ifu_entry_t {pc, inst}.
package ysyx_pkg;

  localparam int              XLEN     = 32;
  localparam logic [XLEN-1:0] RESET_PC = 32'h8000_0000;
  localparam int              INST_W   = 32;

  typedef struct packed {
    logic [XLEN-1:0]   pc;
    logic [INST_W-1:0] inst;
  } ifu_entry_t;

endpackage

// File: rtl/ysyx_ifu_fifo.sv
// rtl/ysyx_ifu_fifo.sv - synchronous FIFO with flush, count and registered head
// Purpose: buffers fetched {pc, inst} words between memory and the IDU.
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   flush            drop all entries (wins over push/pop)
//   push, din        write one entry; caller guarantees a free slot
//   pop              consume head when dout_valid
//   dout_valid, dout registered head entry
//   count            number of stored entries
module ysyx_ifu_fifo #(
  parameter int W     = 64,
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         push,
  input  logic [W-1:0]                 din,
  input  logic                         pop,
  output logic                         dout_valid,
  output logic [W-1:0]                 dout,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr, rd_nxt;
  logic [CW-1:0] cnt_nxt;
  logic          do_pop;
  logic [W-1:0]  head_nxt;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign do_pop = pop && (count != '0);

  // The head register is loaded with whatever will sit at the read pointer
  // after this edge; if the pushed word becomes the head it comes from din.
  always_comb begin
    rd_nxt  = do_pop ? ptr_inc(rd_ptr) : rd_ptr;
    cnt_nxt = count + CW'(push) - CW'(do_pop);
    if (push && ((count - CW'(do_pop)) == '0)) head_nxt = din;
    else                                       head_nxt = mem[rd_nxt];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      dout_valid <= 1'b0;
      dout       <= '0;
    end else if (flush) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      dout_valid <= 1'b0;
    end else begin
      rd_ptr     <= rd_nxt;
      count      <= cnt_nxt;
      dout_valid <= (cnt_nxt != '0);
      if (cnt_nxt != '0) dout <= head_nxt;
      if (push) wr_ptr <= ptr_inc(wr_ptr);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/ysyx_ifu.sv
// rtl/ysyx_ifu.sv - decoupled instruction fetch unit with in-flight tracking
// Purpose: issues in-order word fetches (up to DEPTH in flight), buffers the
// returned words with their PC and hands them to the IDU; redirects flush the
// buffer and discard stale responses.
// Optional feature macro: YSYX_IFU_MISALIGN_CHK_EN (misaligned redirect fault).
// Ports:
//   clk, rst                                   clock, async active-high reset
//   mem_req_valid/ready/addr                   fetch request channel
//   mem_rsp_valid/data                         fetch response (always accepted)
//   redirect_valid/pc                          taken branch / jump from EXU
//   inst_valid/ready, inst, inst_pc            instruction channel to IDU
//   fetch_fault                                sticky misaligned-redirect flag
module ysyx_ifu #(
  parameter int              XLEN     = ysyx_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = ysyx_pkg::RESET_PC,
  parameter int              DEPTH    = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  output logic                        mem_req_valid,
  input  logic                        mem_req_ready,
  output logic [XLEN-1:0]             mem_req_addr,
  input  logic                        mem_rsp_valid,
  input  logic [ysyx_pkg::INST_W-1:0] mem_rsp_data,
  input  logic                        redirect_valid,
  input  logic [XLEN-1:0]             redirect_pc,
  output logic                        inst_valid,
  input  logic                        inst_ready,
  output logic [ysyx_pkg::INST_W-1:0] inst,
  output logic [XLEN-1:0]             inst_pc
`ifdef YSYX_IFU_MISALIGN_CHK_EN
  ,
  output logic                        fetch_fault
`endif
);

  import ysyx_pkg::*;

  localparam int CW = $clog2(DEPTH + 1);
  localparam int EW = XLEN + INST_W;

  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] rsp_pc;      // PC of the next response that will be kept
  logic [XLEN-1:0] target_pc;
  logic [CW-1:0]   outst, drop, outst_nxt, fifo_count;
  logic            req_fire, push, pop, issue_block;
  logic [EW-1:0]   fifo_dout;

`ifdef YSYX_IFU_MISALIGN_CHK_EN
  logic fault_q;

  assign target_pc   = redirect_pc;
  assign issue_block = fault_q;
  assign fetch_fault = fault_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 fault_q <= 1'b0;
    else if (redirect_valid) fault_q <= (redirect_pc[1:0] != 2'b00);
  end
`else
  assign target_pc   = {redirect_pc[XLEN-1:2], 2'b00};
  assign issue_block = 1'b0;
`endif

  // Credits count both in-flight requests and buffered words, so every
  // response is guaranteed a FIFO slot.
  assign mem_req_valid = !rst && !redirect_valid && !issue_block &&
                         ((int'(outst) + int'(fifo_count)) < DEPTH);
  assign mem_req_addr  = fetch_pc;
  assign req_fire      = mem_req_valid && mem_req_ready;
  assign outst_nxt     = outst + CW'(req_fire) - CW'(mem_rsp_valid);

  // A response arriving with a redirect is stale and is never pushed.
  assign push = mem_rsp_valid && !redirect_valid && (drop == '0);
  assign pop  = inst_valid && inst_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      rsp_pc   <= RESET_PC;
      outst    <= '0;
      drop     <= '0;
    end else begin
      outst <= outst_nxt;
      if (redirect_valid) begin
        fetch_pc <= target_pc;
        rsp_pc   <= target_pc;
        drop     <= outst_nxt;
      end else begin
        if (req_fire) fetch_pc <= fetch_pc + XLEN'(4);
        if (push)     rsp_pc   <= rsp_pc + XLEN'(4);
        if (mem_rsp_valid && (drop != '0)) drop <= drop - CW'(1);
      end
    end
  end

  ysyx_ifu_fifo #(
    .W     (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .flush      (redirect_valid),
    .push       (push),
    .din        ({rsp_pc, mem_rsp_data}),
    .pop        (pop),
    .dout_valid (inst_valid),
    .dout       (fifo_dout),
    .count      (fifo_count)
  );

  assign inst_pc = fifo_dout[EW-1:INST_W];
  assign inst    = fifo_dout[INST_W-1:0];

endmodule

// File: tb/tb_ysyx_ifu.sv
// tb/tb_ysyx_ifu.sv - self-checking bench for ysyx_ifu with reference model
module tb_ysyx_ifu;

  localparam int          DEPTH    = 2;
  localparam logic [31:0] RESET_PC = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_req_valid, mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid, inst_ready;
  logic [31:0] inst, inst_pc;
`ifdef YSYX_IFU_MISALIGN_CHK_EN
  logic        fetch_fault;
`endif

  always #5 clk = ~clk;

  ysyx_ifu #(.DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_addr   (mem_req_addr),
    .mem_rsp_valid  (mem_rsp_valid),
    .mem_rsp_data   (mem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_pc        (inst_pc)
`ifdef YSYX_IFU_MISALIGN_CHK_EN
    ,
    .fetch_fault    (fetch_fault)
`endif
  );

  typedef struct { logic [31:0] pc; int due; bit stale; } req_t;
  typedef struct { logic [31:0] pc; logic [31:0] word; } ent_t;

  req_t        infl[$];
  ent_t        fq[$];
  logic [31:0] pop_log[$];
  logic [31:0] req_log[$];
  logic [31:0] exp_pc;
  bit          exp_fault;
  int          cyc, checks, errors;
  int          p_req_rdy, p_inst_rdy, p_redir, lat_min, lat_max;
  bit          force_redir;
  logic [31:0] force_pc;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %h required %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    mem_req_ready = 0; mem_rsp_valid = 0; mem_rsp_data = 0;
    redirect_valid = 0; redirect_pc = 0; inst_ready = 0;
    infl.delete(); fq.delete(); pop_log.delete(); req_log.delete();
    exp_pc = RESET_PC; exp_fault = 0;
    #1;
    chk("rst_req_valid", mem_req_valid, 0);
    chk("rst_req_addr", mem_req_addr, RESET_PC);
    chk("rst_inst_valid", inst_valid, 0);
    chk("rst_inst", inst, 0);
    chk("rst_inst_pc", inst_pc, 0);
`ifdef YSYX_IFU_MISALIGN_CHK_EN
    chk("rst_fault", fetch_fault, 0);
`endif
    @(posedge clk);
    #2 rst = 1'b0;
  endtask

  task automatic step();
    bit          red, rsp, fire, pop, exp_valid;
    logic [31:0] rpc;
    req_t        e;
    @(negedge clk);
    mem_req_ready = ($urandom_range(0, 99) < p_req_rdy);
    inst_ready    = ($urandom_range(0, 99) < p_inst_rdy);
    if (force_redir) begin
      red = 1; rpc = force_pc; force_redir = 0;
    end else begin
      red = ($urandom_range(0, 99) < p_redir);
      rpc = RESET_PC + 32'($urandom_range(0, 1023));
    end
    redirect_valid = red;
    redirect_pc    = rpc;
    rsp = (infl.size() > 0) && (infl[0].due <= cyc);
    mem_rsp_valid = rsp;
    mem_rsp_data  = rsp ? mem_word(infl[0].pc) : $urandom();
    #1;
    exp_valid = !red && !exp_fault && ((infl.size() + fq.size()) < DEPTH);
    chk("mem_req_valid", mem_req_valid, exp_valid);
    if (exp_valid) chk("mem_req_addr", mem_req_addr, exp_pc);
    chk("inst_valid", inst_valid, fq.size() > 0);
    if (fq.size() > 0) begin
      chk("inst_pc", inst_pc, fq[0].pc);
      chk("inst", inst, fq[0].word);
    end
`ifdef YSYX_IFU_MISALIGN_CHK_EN
    chk("fetch_fault", fetch_fault, exp_fault);
`endif
    fire = exp_valid && mem_req_ready;
    pop  = !red && (fq.size() > 0) && inst_ready;
    if (pop) begin
      pop_log.push_back(fq[0].pc);
      void'(fq.pop_front());
    end
    if (rsp) begin
      e = infl.pop_front();
      if (!red && !e.stale) fq.push_back('{e.pc, mem_word(e.pc)});
    end
    if (red) begin
      fq.delete();
      foreach (infl[i]) infl[i].stale = 1;
      exp_pc = {rpc[31:2], 2'b00};
`ifdef YSYX_IFU_MISALIGN_CHK_EN
      exp_fault = (rpc[1:0] != 2'b00);
`endif
    end
    if (fire) begin
      infl.push_back('{exp_pc, cyc + int'($urandom_range(lat_min, lat_max)), 1'b0});
      req_log.push_back(exp_pc);
      exp_pc = exp_pc + 32'd4;
    end
    cyc++;
  endtask

  task automatic knobs(input int rr, input int ir, input int rd, input int lmin, input int lmax);
    p_req_rdy = rr; p_inst_rdy = ir; p_redir = rd; lat_min = lmin; lat_max = lmax;
  endtask

  initial begin
    checks = 0; errors = 0; cyc = 0; force_redir = 0; force_pc = 0;
    knobs(100, 100, 0, 1, 1);

    // Streaming from reset with 1-cycle memory
    do_reset();
    repeat (20) step();
    chk("seq_pc0", pop_log[0], 32'h8000_0000);
    chk("seq_pc1", pop_log[1], 32'h8000_0004);
    chk("seq_pc2", pop_log[2], 32'h8000_0008);

    // IDU stalled: credits stop issue at two requests, then resume
    do_reset();
    knobs(100, 0, 0, 1, 1);
    repeat (10) step();
    chk("stall_req_cnt", req_log.size(), 2);
    chk("stall_req0", req_log[0], 32'h8000_0000);
    chk("stall_req1", req_log[1], 32'h8000_0004);
    chk("stall_no_req", mem_req_valid, 0);
    knobs(100, 100, 0, 1, 1);
    repeat (10) step();
    chk("resume_req2", req_log[2], 32'h8000_0008);
    chk("resume_pc0", pop_log[0], 32'h8000_0000);
    chk("resume_pc1", pop_log[1], 32'h8000_0004);
    chk("resume_pc2", pop_log[2], 32'h8000_0008);

    // Redirect with two requests in flight
    do_reset();
    knobs(100, 0, 0, 4, 4);
    repeat (2) step();
    force_redir = 1; force_pc = 32'h8000_0100;
    step();
    knobs(100, 100, 0, 4, 4);
    repeat (20) step();
    chk("redir_first_pc", pop_log[0], 32'h8000_0100);

    // Memory back-pressure then asynchronous reset mid-stall
    do_reset();
    knobs(100, 100, 0, 1, 1);
    repeat (3) step();
    knobs(0, 100, 0, 1, 1);
    repeat (5) step();
    do_reset();

`ifdef YSYX_IFU_MISALIGN_CHK_EN
    knobs(100, 100, 0, 1, 1);
    repeat (3) step();
    force_redir = 1; force_pc = 32'h8000_0102;
    step();
    begin
      int n;
      n = req_log.size();
      repeat (5) step();
      chk("fault_set", fetch_fault, 1);
      chk("fault_no_req", req_log.size(), n);
      force_redir = 1; force_pc = 32'h8000_0200;
      repeat (10) step();
      chk("fault_clear", fetch_fault, 0);
      chk("fault_resume", req_log[n], 32'h8000_0200);
    end
`endif

    // Randomized traffic with occasional resets
    do_reset();
    for (int blk = 0; blk < 20; blk++) begin
      int lm;
      lm = $urandom_range(1, 4);
      knobs($urandom_range(30, 100), $urandom_range(20, 100), $urandom_range(0, 12), 1, lm);
      for (int k = 0; k < 200; k++) begin
        if ($urandom_range(0, 299) == 0) do_reset();
        step();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
